alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

- Button-driven controller for the shared 4-bit ALU datapath.
- Conditions the operand-load and execute buttons (sync, debounce, edge detect) and owns the A/B operand registers.
- Sequences each ALU operation through a fixed execute/capture handshake, holds the captured result for the LED mux, and counts executed operations.
- Sits between the board switch/button pins and the combinational ALU, replacing direct button-clocked operand registers.

## Interface

Parameters:
- DB_CYCLES, 16'd50000: consecutive stable cycles needed before a conditioned button level changes (min 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-high reset.
- btn_a  in  1  raw button; rising edge loads sw_data into A.
- btn_b  in  1  raw button; rising edge loads sw_data into B.
- btn_go  in  1  raw button; rising edge starts one ALU operation.
- sw_data  in  4  operand value from switches.
- sw_op  in  2  ALU opcode from switches.
- alu_y  in  4  combinational ALU result.
- alu_a  out  4  operand A register to the ALU.
- alu_b  out  4  operand B register to the ALU.
- alu_op  out  2  opcode latched at go.
- result  out  4  last captured ALU result.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high in any state other than IDLE.
- op_count  out  8  number of completed operations, wraps 255 -> 0.

## Operation

- Every button uses a 2-flop synchronizer and a debounce counter.
  - The counter clears whenever the synchronized input equals the conditioned level.
  - When it reaches DB_CYCLES - 1 while the input still differs, the level flips on the next edge.
  - A conditioned rising edge gives a one-cycle pulse. Falling edges give no pulse.
- IDLE:
  - a_pulse loads alu_a <= sw_data; b_pulse loads alu_b <= sw_data. Both may load in the same cycle.
  - go_pulse latches alu_op <= sw_op and moves the FSM to EXEC. A go in the same cycle as a load still applies the load, so EXEC uses the new value.
- EXEC: operands and op are held stable for one settle cycle -> CAPTURE.
- CAPTURE: result <= alu_y, op_count increments (wrapping), result_valid = 1 for this cycle -> IDLE.
- In EXEC and CAPTURE, all button pulses are dropped. They are not queued.
- Operands and result are plain 4-bit values. No carry or overflow is stored.
- A reset assertion at any point forces IDLE immediately. An in-flight operation does not capture.
- The FSM states are IDLE, EXEC, CAPTURE. Unused encodings go to IDLE.

## Timing

- Reset values:
  - alu_a, alu_b, alu_op, result, op_count = 0.
  - result_valid = 0, busy = 0.
  - All conditioned levels = 0 and debounce counters = 0.
- Button latency: with the raw input high from edge 0 onward, the pulse is high in the cycle after edge DB_CYCLES + 2.
- Go to result: with go_pulse in cycle n, EXEC is cycle n+1 and CAPTURE is cycle n+2.
  - result_valid is high in cycle n+2.
  - result, op_count and busy = 0 are visible from cycle n+3.
- busy is high in exactly cycles n+1 and n+2.
- Minimum spacing between accepted operations is 3 cycles. Pulses are always at least DB_CYCLES apart in practice.

## Configuration

- ALU_CHAIN_EN defined: in CAPTURE, alu_a is also written with alu_y (accumulator mode).
  - Repeated go presses apply sw_op and B to the running result, modulo 16.
  - An a_pulse still overrides A in IDLE.
- ALU_CHAIN_EN undefined: alu_a changes only on a_pulse or reset.

## Structure

- Shared package alu_pkg holds:
  - the state enum (IDLE, EXEC, CAPTURE);
  - operand and opcode width constants (DATA_W = 4, OP_W = 2);
  - the op_count width (CNT_W = 8).
- One sub-module, btn_conditioner (sync, debounce, rising-edge pulse, parameter DB_CYCLES), instantiated three times.
- The sequencer FSM, operand registers and counter stay in the top module.

## Test plan

All scenarios use DB_CYCLES = 4 and a bench ALU model where op 00 = A + B mod 16.

- Load and execute:
  - Stimulus: sw_data = 3, press btn_a; sw_data = 5, press btn_b; sw_op = 00, press go.
  - Response: alu_a = 3, alu_b = 5, result = 8, result_valid high for exactly 1 cycle, op_count = 1, busy high for 2 cycles.
- Bounce rejection:
  - Stimulus: btn_a toggles every 2 cycles for 20 cycles, then stays high.
  - Response: exactly one a_pulse, alu_a loaded once.
- Busy drop:
  - Stimulus: force a b_pulse and a go_pulse during EXEC.
  - Response: alu_b unchanged, no second operation, op_count increments once.
- Counter wrap:
  - Stimulus: 256 operations.
  - Response: op_count = 0, and the 257th operation gives op_count = 1.
- Reset mid-operation:
  - Stimulus: assert clr during EXEC after A = 7, B = 2.
  - Response: all outputs 0 asynchronously, no result_valid, state IDLE.
- Chain mode (ALU_CHAIN_EN only):
  - Stimulus: A = 9, B = 4, three go presses with op 00.
  - Response: results 13, 1, 5 and alu_a tracks each result.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types and widths for the button-driven ALU sequencer.
//   state_t  : sequencer states (IDLE, EXEC, CAPTURE)
//   DATA_W   : operand/result width
//   OP_W     : opcode width
//   CNT_W    : completed-operation counter width
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// ALU-side bus between the sequencer and the combinational ALU / LED mux.
//   alu_a, alu_b, alu_op : operands and opcode presented to the ALU
//   alu_y                : combinational ALU result
//   result, result_valid : captured result and its one-cycle update pulse
//   busy, op_count       : sequencer activity flag and completed-op counter
// Modports: master = sequencer, slave = ALU / result consumer.
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  modport master (
    output alu_a, alu_b, alu_op, result, result_valid, busy, op_count,
    input  alu_y
  );

  modport slave (
    input  alu_a, alu_b, alu_op, result, result_valid, busy, op_count,
    output alu_y
  );

endinterface

// File: rtl/alu_op_sequencer_btn_conditioner.sv
// btn_conditioner
// Conditions one raw board button: 2-flop synchronizer, debounce counter,
// and a one-cycle pulse on each conditioned rising edge.
//   clk   : system clock
//   clr   : asynchronous active-high reset
//   raw   : raw button pin
//   pulse : one-cycle pulse per accepted press (falling edges give none)
// Parameter DB_CYCLES: stable cycles needed before the level flips (min 1).
module btn_conditioner #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic pulse
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic        level_d;
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // Registered edge detect keeps the pulse glitch-free for the FSM.
      pulse   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_CYCLES - 16'd1) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Button-driven controller for the shared 4-bit ALU. Owns the A/B operand
// registers, latches the opcode at go, sequences IDLE -> EXEC -> CAPTURE,
// holds the captured result and counts completed operations.
//   clk     : system clock
//   clr     : asynchronous active-high reset
//   btn_a   : raw button, loads sw_data into A
//   btn_b   : raw button, loads sw_data into B
//   btn_go  : raw button, starts one ALU operation
//   sw_data : operand switches
//   sw_op   : opcode switches
//   bus     : ALU-side interface (master modport)
// Build option ALU_CHAIN_EN: CAPTURE also writes the result back into A,
// turning A into an accumulator.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              btn_a,
  input  logic              btn_b,
  input  logic              btn_go,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [OP_W-1:0]   sw_op,
  alu_op_sequencer_if.master bus
);

  // state   | meaning
  // IDLE    | accept operand loads and go
  // EXEC    | operands/op held one cycle for the ALU to settle
  // CAPTURE | result registered, op_count bumped, result_valid high

  logic a_pulse;
  logic b_pulse;
  logic go_pulse;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_a (
    .clk(clk), .clr(clr), .raw(btn_a), .pulse(a_pulse)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_b (
    .clk(clk), .clr(clr), .raw(btn_b), .pulse(b_pulse)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_go (
    .clk(clk), .clr(clr), .raw(btn_go), .pulse(go_pulse)
  );

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [OP_W-1:0]   reg_op;
  logic [DATA_W-1:0] reg_result;
  logic [CNT_W-1:0]  reg_count;
  logic              busy;
  logic              result_valid;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go_pulse) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Button pulses outside IDLE are intentionally dropped, not queued.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      reg_a      <= '0;
      reg_b      <= '0;
      reg_op     <= '0;
      reg_result <= '0;
      reg_count  <= '0;
    end else begin
      if (state == IDLE) begin
        if (a_pulse) begin
          reg_a <= sw_data;
        end
        if (b_pulse) begin
          reg_b <= sw_data;
        end
        if (go_pulse) begin
          reg_op <= sw_op;
        end
      end
      if (state == CAPTURE) begin
        reg_result <= bus.alu_y;
        reg_count  <= reg_count + 1'b1;
`ifdef ALU_CHAIN_EN
        reg_a      <= bus.alu_y;
`else
`endif
      end
    end
  end

  assign bus.alu_a        = reg_a;
  assign bus.alu_b        = reg_b;
  assign bus.alu_op       = reg_op;
  assign bus.result       = reg_result;
  assign bus.result_valid = result_valid;
  assign bus.busy         = busy;
  assign bus.op_count     = reg_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam logic [15:0] DB   = 16'd4;
  localparam int          HOLD = 14;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic       btn_go = 1'b0;
  logic [3:0] sw_data = 4'd0;
  logic [1:0] sw_op = 2'd0;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.DB_CYCLES(DB)) dut (
    .clk(clk), .clr(clr), .btn_a(btn_a), .btn_b(btn_b), .btn_go(btn_go),
    .sw_data(sw_data), .sw_op(sw_op), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // bench-side combinational ALU
  always_comb bus.alu_y = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

  typedef struct packed {
    logic [3:0] res;
    logic [7:0] cnt;
    logic [3:0] a;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   busy_cycles = 0;
  int   rv_cycles = 0;
  int   a_changes = 0;
  logic [3:0] a_prev = 4'd0;

  logic [3:0] ref_a = 4'd0;
  logic [3:0] ref_b = 4'd0;
  logic [7:0] ref_cnt = 8'd0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_cycles++;
    if (bus.result_valid === 1'b1) rv_cycles++;
    if (bus.alu_a !== a_prev) a_changes++;
    a_prev = bus.alu_a;
  end

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_result_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("busy_in_capture", int'(bus.busy), 1);
          @(posedge clk);
          #1;
          check("result", int'(bus.result), int'(e.res));
          check("op_count", int'(bus.op_count), int'(e.cnt));
          check("alu_a_after_op", int'(bus.alu_a), int'(e.a));
          check("busy_after_op", int'(bus.busy), 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_op(logic [1:0] op);
    logic [3:0] r;
    r = alu_f(ref_a, ref_b, op);
    ref_cnt = ref_cnt + 8'd1;
`ifdef ALU_CHAIN_EN
    ref_a = r;
`endif
    sbq.push_back({r, ref_cnt, ref_a});
  endtask

  task automatic press_a(logic [3:0] d);
    sw_data = d;
    btn_a = 1'b1;
    tick(HOLD);
    btn_a = 1'b0;
    tick(HOLD);
    ref_a = d;
  endtask

  task automatic press_b(logic [3:0] d);
    sw_data = d;
    btn_b = 1'b1;
    tick(HOLD);
    btn_b = 1'b0;
    tick(HOLD);
    ref_b = d;
  endtask

  task automatic press_go(logic [1:0] op);
    sw_op = op;
    btn_go = 1'b1;
    expect_op(op);
    tick(HOLD);
    btn_go = 1'b0;
    tick(HOLD);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_alu_a"}, int'(bus.alu_a), 0);
    check({tag, "_alu_b"}, int'(bus.alu_b), 0);
    check({tag, "_alu_op"}, int'(bus.alu_op), 0);
    check({tag, "_result"}, int'(bus.result), 0);
    check({tag, "_result_valid"}, int'(bus.result_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_op_count"}, int'(bus.op_count), 0);
  endtask

  initial begin
    int bc;
    int rc;
    int ac;
    int lat;
    logic [3:0] chain_exp [3];

    // reset state
    #3;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b0;
    tick(2);

    // load and execute, with go-to-busy latency
    press_a(4'd3);
    check("load_a", int'(bus.alu_a), 3);
    press_b(4'd5);
    check("load_b", int'(bus.alu_b), 5);
    bc = busy_cycles;
    rc = rv_cycles;
    sw_op = 2'd0;
    btn_go = 1'b1;
    expect_op(2'd0);
    lat = 0;
    while (bus.busy !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("go_to_busy_latency", lat, int'(DB) + 5);
    tick(HOLD);
    btn_go = 1'b0;
    tick(HOLD);
    check("busy_cycles_per_op", busy_cycles - bc, 2);
    check("result_valid_cycles", rv_cycles - rc, 1);
    check("first_result", int'(bus.result), 8);
    check("first_count", int'(bus.op_count), 1);

    // bounce rejection
    ac = a_changes;
    sw_data = 4'd10;
    for (int i = 0; i < 10; i++) begin
      btn_a = ~btn_a;
      tick(2);
    end
    sw_data = 4'd11;
    btn_a = 1'b1;
    tick(HOLD);
    btn_a = 1'b0;
    tick(HOLD);
    ref_a = 4'd11;
    check("bounce_a_loads", a_changes - ac, 1);
    check("bounce_a_value", int'(bus.alu_a), 11);

    // pulses during EXEC / CAPTURE are dropped
    sw_data = 4'd12;
    sw_op = 2'd1;
    btn_go = 1'b1;
    expect_op(2'd1);
    tick(1);
    btn_b = 1'b1;
    tick(1);
    btn_a = 1'b1;
    tick(HOLD);
    btn_go = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick(HOLD);
    check("drop_alu_b", int'(bus.alu_b), int'(ref_b));
    check("drop_alu_a", int'(bus.alu_a), int'(ref_a));
    check("drop_count", int'(bus.op_count), int'(ref_cnt));

    // reset mid-operation
    press_a(4'd7);
    press_b(4'd2);
    sw_op = 2'd0;
    btn_go = 1'b1;
    expect_op(2'd0);
    lat = 0;
    while (bus.busy !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("midop_reached_exec", int'(bus.busy), 1);
    rc = rv_cycles;
    clr = 1'b1;
    btn_go = 1'b0;
    #1;
    check_all_zero("midop_reset");
    sbq.delete();
    ref_a = 4'd0;
    ref_b = 4'd0;
    ref_cnt = 8'd0;
    tick(3);
    clr = 1'b0;
    tick(HOLD);
    check("midop_no_result_valid", rv_cycles - rc, 0);
    check("midop_idle", int'(bus.busy), 0);
    check("midop_count", int'(bus.op_count), 0);

    // randomized run to counter wrap
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) press_a(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) press_b(4'($urandom_range(0, 15)));
      press_go(2'($urandom_range(0, 3)));
    end
    check("wrap_count_256", int'(bus.op_count), 0);
    press_go(2'($urandom_range(0, 3)));
    check("wrap_count_257", int'(bus.op_count), 1);

    // accumulator scenario
`ifdef ALU_CHAIN_EN
    chain_exp[0] = 4'd13;
    chain_exp[1] = 4'd1;
    chain_exp[2] = 4'd5;
`else
    chain_exp[0] = 4'd13;
    chain_exp[1] = 4'd13;
    chain_exp[2] = 4'd13;
`endif
    press_a(4'd9);
    press_b(4'd4);
    for (int i = 0; i < 3; i++) begin
      press_go(2'd0);
      check("chain_result", int'(bus.result), int'(chain_exp[i]));
`ifdef ALU_CHAIN_EN
      check("chain_alu_a", int'(bus.alu_a), int'(chain_exp[i]));
`else
      check("chain_alu_a", int'(bus.alu_a), 9);
`endif
    end

    tick(10);
    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
